adjust_mode_sequencer: RTL and testbench
========================================

// Module: adjust_mode_sequencer
// PURPOSE
//  Front-end controller for time adjustment. Synchronises and debounces the MODE and INC buttons.
//  Steps a one-hot field-select FSM RUN->HOURS->MINUTES->SECONDS->RUN and drives the adjust_mode/adjust_increment
//  inputs of the increment-control datapath. Falls back to RUN after an inactivity timeout; sits between board buttons and adjust logic.
// PARAMETERS
//  DEBOUNCE_CYCLES  16    clk cycles a synchronised button level must stay stable before being accepted (>=1)
//  TIMEOUT_TICKS    10    tick pulses of no button activity in an adjust state before forced return to RUN (>=1)
//  BLINK_TICKS      1     tick pulses per half-period of blink output (only with ADJUST_BLINK_EN, >=1)
// PORTS
//  clk               in   1  system clock, all state on posedge
//  rst_n             in   1  asynchronous active-low reset
//  tick              in   1  single-cycle timebase strobe (e.g. 1 Hz enable)
//  btn_mode          in   1  raw MODE button, active-high, asynchronous
//  btn_inc           in   1  raw INC button, active-high, asynchronous
//  adjust_mode       out  3  {hours,minutes,seconds} one-hot field select; 3'b000 = RUN
//  adjust_increment  out  1  debounced INC level, gated to 0 in RUN
//  adjust_active     out  1  1 when state != RUN (timekeeping hold)
//  blink             out  1  display blanking phase for selected field
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=RUN, adjust_mode=000, adjust_increment=0, adjust_active=0, blink=0.
//    Sync flops, debounced levels and all counters = 0. Outputs registered; clean reset mid-adjust returns to RUN.
//  - Per button: 2-flop synchroniser -> debounce counter; counter clears when sync level == debounced level.
//    Otherwise increments; at DEBOUNCE_CYCLES-1 debounced level takes sync level, counter clears.
//    A glitch shorter than DEBOUNCE_CYCLES cycles is ignored.
//  - mode_press = 1-cycle rising edge of debounced MODE. Release is ignored.
//  - FSM (states encode adjust_mode directly): RUN 000 -> HOURS 100 -> MINUTES 010 -> SECONDS 001 -> RUN.
//    Advances one step per mode_press; adjust_mode changes the cycle after mode_press.
//  - adjust_increment = debounced INC && state != RUN, registered. Repeat timing is left to the increment-control datapath.
//    That datapath restarts its repeat delay on a mode change.
//  - INC held across a mode_press: adjust_increment stays 1 into the new field. Leaving SECONDS forces it to 0 the cycle RUN is entered.
//  - INC pressed in RUN: no effect on any output.
//  - Timeout counter: width $clog2(TIMEOUT_TICKS+1). Cleared in RUN, on mode_press, and while debounced INC=1.
//    Otherwise +1 per tick, saturating.
//    At TIMEOUT_TICKS: state->RUN next cycle, counter cleared.
//  - mode_press in the same cycle as timeout expiry: mode_press wins (normal step), counter cleared.
//  - tick is ignored when not in an adjust state; tick in the same cycle as INC activity does not count.
// CONFIGURATION
//  ADJUST_BLINK_EN defined:
//   - blink toggles every BLINK_TICKS tick pulses while adjust_active=1.
//   - Forced 0 in RUN and for the first cycle after any state change (phase restarts "visible").
//   - Held 0 while adjust_increment=1 so the field stays visible during adjustment.
//  ADJUST_BLINK_EN undefined: blink tied 0; blink counter not instantiated.
// TESTING (DEBOUNCE_CYCLES=4, TIMEOUT_TICKS=3, BLINK_TICKS=1)
//  - Reset: rst_n=0 asynchronously mid-HOURS -> adjust_mode=000, adjust_increment=0, blink=0 without a clk edge.
//  - Debounce: btn_mode pulses 2 cycles -> no change. Held 10 cycles -> exactly one step 000->100.
//    Debounce latency 2 sync + 4 stable + 1 register cycles.
//  - Cycle: 4 clean MODE presses -> adjust_mode 100,010,001,000, one step each, adjust_active high during the first three.
//  - INC gating: INC held in RUN -> adjust_increment=0. INC held in MINUTES -> adjust_increment=1 until release or exit to RUN.
//  - Timeout: enter HOURS, idle, 3 tick pulses -> adjust_mode=000. INC held across 5 ticks, then released -> no timeout until 3 further ticks.
//  - Collision: mode_press on same cycle as 3rd tick in HOURS -> MINUTES (not RUN); counter 0.
//    Blink (EN): toggles each tick in SECONDS, 0 while INC held.

Source files
------------

// File: rtl/adjust_mode_sequencer.sv
// Purpose: debounced MODE/INC front end stepping the RUN->HOURS->MINUTES->SECONDS field select, with inactivity timeout.
// Latency: button edge to output is 2 sync + DEBOUNCE_CYCLES stable + 1 register cycles; tick-driven timeout lands the cycle after the expiring tick.
// Backpressure: none; buttons are levels and tick is a strobe, so nothing is ever stalled. Optional blink output under ADJUST_BLINK_EN.
module adjust_mode_sequencer #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_TICKS   = 10,
    parameter int BLINK_TICKS     = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [2:0] adjust_mode,
    output logic       adjust_increment,
    output logic       adjust_active,
    output logic       blink
);

    localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TOW = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TOW-1:0] TO_LAST = TOW'(TIMEOUT_TICKS - 1);
    localparam logic [TOW-1:0] TO_MAX  = TOW'(TIMEOUT_TICKS);

    // State codes double as the one-hot field select seen by the datapath.
    typedef enum logic [2:0] {
        ST_RUN     = 3'b000,
        ST_HOURS   = 3'b100,
        ST_MINUTES = 3'b010,
        ST_SECONDS = 3'b001
    } state_t;

    state_t state;
    state_t state_nxt;

    // Bit 0 carries MODE, bit 1 carries INC through the shared debounce path.
    logic [1:0]     btn_raw;
    logic [1:0]     sync1;
    logic [1:0]     sync2;
    logic [1:0]     deb;
    logic [DBW-1:0] db_cnt [2];
    logic           mode_q;
    logic           mode_press;
    logic           inc_lvl;
    logic           in_adjust;
    logic           timeout_hit;
    logic [TOW-1:0] to_cnt;
    logic           active_d;
    logic           inc_d;

    assign btn_raw = {btn_inc, btn_mode};

    // Two-flop synchronisers followed by a stability counter per button.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= 2'b00;
            sync2     <= 2'b00;
            deb       <= 2'b00;
            db_cnt[0] <= '0;
            db_cnt[1] <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    deb[i]    <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Delayed debounced MODE level for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= 1'b0;
        end else begin
            mode_q <= deb[0];
        end
    end

    assign mode_press = deb[0] & ~mode_q;
    assign inc_lvl    = deb[1];
    assign in_adjust  = (state != ST_RUN);

    // Expiry happens on the tick that would bring the idle count to TIMEOUT_TICKS.
    assign timeout_hit = in_adjust && tick && !inc_lvl && (to_cnt >= TO_LAST);

    // Inactivity counter: only idle ticks inside an adjust state advance it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (!in_adjust || mode_press || inc_lvl || timeout_hit) begin
            to_cnt <= '0;
        end else if (tick && (to_cnt != TO_MAX)) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: a MODE press always steps the field, even when the timeout expires in the same cycle.
    always_comb begin
        state_nxt = state;
        if (mode_press) begin
            case (state)
                ST_RUN:     state_nxt = ST_HOURS;
                ST_HOURS:   state_nxt = ST_MINUTES;
                ST_MINUTES: state_nxt = ST_SECONDS;
                default:    state_nxt = ST_RUN;
            endcase
        end else if (timeout_hit) begin
            state_nxt = ST_RUN;
        end
    end

    // Output decode from the upcoming state so outputs register in step with the state.
    always_comb begin
        active_d = (state_nxt != ST_RUN);
        inc_d    = inc_lvl && active_d;
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adjust_increment <= 1'b0;
            adjust_active    <= 1'b0;
        end else begin
            adjust_increment <= inc_d;
            adjust_active    <= active_d;
        end
    end

    assign adjust_mode = state;

`ifdef ADJUST_BLINK_EN
    localparam int BLW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [BLW-1:0] BL_LAST = BLW'(BLINK_TICKS - 1);

    logic           blink_q;
    logic [BLW-1:0] bl_cnt;

    // Blink phase restarts visible on any field change and stays visible while incrementing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_q <= 1'b0;
            bl_cnt  <= '0;
        end else if (!active_d || (state_nxt != state) || inc_d) begin
            blink_q <= 1'b0;
            bl_cnt  <= '0;
        end else if (tick) begin
            if (bl_cnt == BL_LAST) begin
                blink_q <= ~blink_q;
                bl_cnt  <= '0;
            end else begin
                bl_cnt <= bl_cnt + 1'b1;
            end
        end
    end

    assign blink = blink_q;
`else
    logic unused_blink_cfg;
    assign unused_blink_cfg = (BLINK_TICKS != 0);
    assign blink            = 1'b0;
`endif

endmodule

// File: tb/tb_adjust_mode_sequencer.sv
// Bench for adjust_mode_sequencer with DEBOUNCE_CYCLES=4, TIMEOUT_TICKS=3, BLINK_TICKS=1.
// Expected {adjust_mode, adjust_increment, adjust_active} changes are queued ahead of stimulus;
// a monitor pops one entry per observed output change and compares.
module tb_adjust_mode_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       tick = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [2:0] adjust_mode;
    logic       adjust_increment;
    logic       adjust_active;
    logic       blink;

    int n_checks = 0;
    int n_pass   = 0;
    int lat;
    logic [4:0] exp_q[$];

    adjust_mode_sequencer #(
        .DEBOUNCE_CYCLES(4),
        .TIMEOUT_TICKS  (3),
        .BLINK_TICKS    (1)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .tick            (tick),
        .btn_mode        (btn_mode),
        .btn_inc         (btn_inc),
        .adjust_mode     (adjust_mode),
        .adjust_increment(adjust_increment),
        .adjust_active   (adjust_active),
        .blink           (blink)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic expect_ev(input logic [2:0] m, input logic i, input logic a);
        exp_q.push_back({m, i, a});
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_mode();
        btn_mode = 1'b1;
        cyc(10);
        btn_mode = 1'b0;
        cyc(10);
    endtask

    task automatic give_tick();
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
        cyc(3);
    endtask

    task automatic set_inc(input logic v);
        btn_inc = v;
        cyc(10);
    endtask

    // Monitor: every change of the observed outputs must match the next queued expectation.
    initial begin
        logic [4:0] prev;
        logic [4:0] cur;
        logic [4:0] e;
        prev = 5'b0;
        forever begin
            @(negedge clk);
            cur = {adjust_mode, adjust_increment, adjust_active};
            if (cur !== prev) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_output: got %b, no change expected", cur);
                end else begin
                    e = exp_q.pop_front();
                    chk("output_event", int'(cur), int'(e));
                end
`ifndef ADJUST_BLINK_EN
                chk("blink_tied", int'(blink), 0);
`endif
                prev = cur;
            end
        end
    end

    initial begin
        // Reset state
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mode", int'(adjust_mode), 0);
        chk("rst_inc", int'(adjust_increment), 0);
        chk("rst_active", int'(adjust_active), 0);
        chk("rst_blink", int'(blink), 0);
        cyc(3);
        rst_n = 1'b1;
        cyc(3);

        // Ticks in RUN do nothing
        repeat (4) give_tick();
        chk("run_ticks_ignored", int'(adjust_mode), 0);

        // Short MODE glitch is filtered
        btn_mode = 1'b1;
        cyc(2);
        btn_mode = 1'b0;
        cyc(15);
        chk("glitch_ignored", int'(adjust_mode), 0);

        // Held press: one step, 7-cycle latency
        expect_ev(3'b100, 1'b0, 1'b1);
        btn_mode = 1'b1;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            cyc(1);
            if (adjust_mode != 3'b000) begin
                lat = i;
                break;
            end
        end
        chk("debounce_latency", lat, 7);
        cyc(5);
        btn_mode = 1'b0;
        cyc(10);
        chk("hold_one_step", int'(adjust_mode), 4);

        // Remaining field cycle
        expect_ev(3'b010, 1'b0, 1'b1);
        press_mode();
        expect_ev(3'b001, 1'b0, 1'b1);
        press_mode();
        expect_ev(3'b000, 1'b0, 1'b0);
        press_mode();

        // INC gating
        set_inc(1'b1);
        cyc(5);
        chk("inc_gated_run", int'(adjust_increment), 0);
        expect_ev(3'b100, 1'b1, 1'b1);
        press_mode();
        expect_ev(3'b010, 1'b1, 1'b1);
        press_mode();
        expect_ev(3'b010, 1'b0, 1'b1);
        set_inc(1'b0);
        expect_ev(3'b010, 1'b1, 1'b1);
        set_inc(1'b1);
        expect_ev(3'b001, 1'b1, 1'b1);
        press_mode();
        expect_ev(3'b000, 1'b0, 1'b0);
        press_mode();
        set_inc(1'b0);

        // Idle timeout
        expect_ev(3'b100, 1'b0, 1'b1);
        press_mode();
        give_tick();
        give_tick();
        chk("before_timeout", int'(adjust_mode), 4);
        expect_ev(3'b000, 1'b0, 1'b0);
        give_tick();
        chk("timeout_run", int'(adjust_mode), 0);

        // INC activity holds off the timeout
        expect_ev(3'b100, 1'b0, 1'b1);
        press_mode();
        expect_ev(3'b100, 1'b1, 1'b1);
        set_inc(1'b1);
        repeat (5) give_tick();
        chk("inc_holds_timeout", int'(adjust_mode), 4);
        expect_ev(3'b100, 1'b0, 1'b1);
        set_inc(1'b0);
        give_tick();
        give_tick();
        chk("no_early_timeout", int'(adjust_mode), 4);
        expect_ev(3'b000, 1'b0, 1'b0);
        give_tick();
        chk("late_timeout", int'(adjust_mode), 0);

        // mode_press coinciding with the expiring tick
        expect_ev(3'b100, 1'b0, 1'b1);
        press_mode();
        give_tick();
        give_tick();
        expect_ev(3'b010, 1'b0, 1'b1);
        btn_mode = 1'b1;
        cyc(6);
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
        chk("collision_minutes", int'(adjust_mode), 2);
        cyc(3);
        btn_mode = 1'b0;
        cyc(10);
        give_tick();
        give_tick();
        chk("collision_cnt_cleared", int'(adjust_mode), 2);
        expect_ev(3'b000, 1'b0, 1'b0);
        give_tick();
        chk("collision_then_timeout", int'(adjust_mode), 0);

`ifdef ADJUST_BLINK_EN
        // Blink in SECONDS
        expect_ev(3'b100, 1'b0, 1'b1);
        press_mode();
        expect_ev(3'b010, 1'b0, 1'b1);
        press_mode();
        expect_ev(3'b001, 1'b0, 1'b1);
        press_mode();
        chk("blink_enter", int'(blink), 0);
        give_tick();
        chk("blink_tick1", int'(blink), 1);
        give_tick();
        chk("blink_tick2", int'(blink), 0);
        expect_ev(3'b001, 1'b1, 1'b1);
        set_inc(1'b1);
        give_tick();
        chk("blink_held_inc", int'(blink), 0);
        expect_ev(3'b001, 1'b0, 1'b1);
        set_inc(1'b0);
        give_tick();
        chk("blink_resume", int'(blink), 1);
        give_tick();
        chk("blink_resume2", int'(blink), 0);
        expect_ev(3'b000, 1'b0, 1'b0);
        give_tick();
        chk("blink_run", int'(blink), 0);
`endif

        // Asynchronous reset in the middle of HOURS with INC active
        expect_ev(3'b100, 1'b0, 1'b1);
        press_mode();
        expect_ev(3'b100, 1'b1, 1'b1);
        set_inc(1'b1);
        expect_ev(3'b000, 1'b0, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_mode", int'(adjust_mode), 0);
        chk("arst_inc", int'(adjust_increment), 0);
        chk("arst_active", int'(adjust_active), 0);
        chk("arst_blink", int'(blink), 0);
        btn_inc = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        cyc(5);

        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
